mpc_seq: RTL
============

# mpc_seq

Instruction sequencer that sits directly upstream of the `mpc` ALU stage. It buffers a short program of 18-bit instruction words and then issues them one per cycle on a valid/ready handshake. Each issued word is the ALU stage's `ins` input. A host loads the program word by word, pulses `start`, and gets a `done` pulse after the last word has issued.

## Interface
Parameters:
- `DEPTH`, 16: program buffer entries; power of two, 2..256.
- `INS_W`, 18: instruction width; fixed to match the ALU stage.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; appends `wr_data` to the buffer.
- `wr_data`  in  INS_W  instruction word to append.
- `clear`  in  1  empties the buffer; honoured in IDLE only.
- `start`  in  1  begins one issue pass; sampled in IDLE only.
- `ins_ready`  in  1  downstream can accept the current word.
- `ins`  out  INS_W  issued instruction word, registered.
- `ins_valid`  out  1  `ins` is valid this cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a pass completes.
- `count`  out  $clog2(DEPTH)+1  number of loaded words.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- States:
  - IDLE: loading is allowed.
  - RUN: words are being issued.
  - DONE: one cycle, drives the `done` pulse.
- Reset values: state IDLE; `count`=0; read/write pointers 0; `ins`=0; `ins_valid`=0; `busy`=0; `done`=0; `overflow`=0. Buffer contents are don't-care.
- Load rules, IDLE only:
  - `wr_en` with `count`<DEPTH writes entry `count` and increments `count`.
  - `wr_en` with `count`==DEPTH drops the word and sets `overflow`.
  - `wr_en` in RUN or DONE is dropped and sets `overflow`.
- `clear` in IDLE sets `count`=0 and clears `overflow`. If `clear` and `wr_en` coincide, `clear` wins and the word is dropped without setting `overflow`. `clear` outside IDLE is ignored.
- IDLE to RUN: `start` with `count`>0, at read pointer 0.
- IDLE to DONE: `start` with `count`==0; no word is issued.
- In RUN, `ins_valid`=1 and `ins`=entry[rd_ptr].
  - A transfer happens when `ins_valid && ins_ready`.
  - On a transfer, rd_ptr advances. If the transferred word was entry `count`-1, the state goes to DONE.
  - Without `ins_ready`, `ins` and `ins_valid` hold.
- DONE to IDLE unconditionally. The program is retained, so a new `start` replays it.
- `start` outside IDLE is ignored. If `start` and `wr_en` arrive in the same IDLE cycle, the write completes first and the pass includes the new word.
- `ins` is driven to 0 whenever `ins_valid`=0.
- `rst` mid-RUN aborts immediately: outputs return to reset values, and no `done` pulse is produced.

## Timing
- `start` sampled at edge 0: `busy` and `ins_valid` are high from edge 0, and entry 0 is presented after edge 0.
- With `ins_ready` held high, entry k is presented in cycle k+1. `done` is high in cycle `count`+1; `busy` is low from that cycle.
- Each stalled cycle (`ins_ready`=0 while valid) adds exactly one cycle to the pass.
- Empty start: `done` high in the cycle after `start`.
- A write updates `count` in the following cycle.

## Configuration
- Macro: `MPC_SEQ_LOOP_EN`.
- When defined:
  - Adds input port `loop` (1 bit).
  - If `loop`=1 at the transfer of entry `count`-1, rd_ptr wraps to 0 and the state stays in RUN with no bubble cycle and no `done`.
  - If `loop`=0 at that transfer, the state goes to DONE as normal.
- When undefined: the `loop` port is absent and every pass is single-shot.

## Structure
- Shared package `mpc_pkg`:
  - `INS_W`=18.
  - `RES_W`=9.
  - Opcode constants in `ins[17:16]`: `OP_DEC`=2'b00, `OP_SUB`=2'b01, `OP_INC`=2'b10, `OP_ADD`=2'b11.
  - State enum `seq_state_t`: IDLE, RUN, DONE.
- Sub-module `mpc_seq_mem`: DEPTH×INS_W register file with one synchronous write port and one combinational read port. The FSM, pointers and output register live in `mpc_seq`.

## Test plan
- Reset mid-RUN with DEPTH=16: load 3 words, pulse `start`, assert `rst` in cycle 2. All outputs are 0 immediately and no `done` pulse follows.
- Basic pass: load 18'h30503 and 18'h00A00, then `start`. In cycle 1 `ins`=18'h30503 and the downstream ALU result is 9'd8. In cycle 2 `ins`=18'h00A00. `done` is high in cycle 3; `count` stays 2.
- Stall: the same 2-word program with `ins_ready` low in cycles 1–2. `ins` holds 18'h30503 through cycle 3, and `done` moves to cycle 5.
- Full/overflow: 17 writes with DEPTH=16 give `count`=16 and `overflow`=1. `clear` then gives `count`=0 and `overflow`=0. `start` on the empty buffer gives `done` in the next cycle and no `ins_valid`.
- Ignored inputs in RUN: `wr_en` sets `overflow`, and `start` or `clear` has no effect.
- Loop (`MPC_SEQ_LOOP_EN`): with 2 words and `loop`=1, words alternate for 6 cycles. Dropping `loop` before an entry-1 transfer gives `done` in the next cycle.

Source files
------------

// File: rtl/mpc_pkg.sv
// Shared definitions for the mpc datapath: instruction/result widths, opcodes
// and the sequencer state encoding.
package mpc_pkg;

  localparam int INS_W = 18;
  localparam int RES_W = 9;

  localparam logic [1:0] OP_DEC = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mpc_seq_mem.sv
// Program buffer for mpc_seq: DEPTH x INS_W register file with one synchronous
// write port and one combinational read port. Contents are not reset.
module mpc_seq_mem #(
  parameter int DEPTH = 16,
  parameter int INS_W = 18
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [INS_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [INS_W-1:0]         rdata_o
);
  import mpc_pkg::*;

  logic [INS_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mpc_seq.sv
// Instruction sequencer feeding the mpc ALU stage: loads a short program, then
// issues it one word per valid/ready transfer. MPC_SEQ_LOOP_EN adds loop_i replay.
//
// state | meaning
// IDLE  | program load / clear allowed, waiting for start
// RUN   | words issued on ins_o, one per transfer
// DONE  | single cycle, drives the done pulse
module mpc_seq #(
  parameter int DEPTH = 16,
  parameter int INS_W = mpc_pkg::INS_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef MPC_SEQ_LOOP_EN
  input  logic                     loop_i,
`endif
  input  logic                     wr_en_i,
  input  logic [INS_W-1:0]         wr_data_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic                     ins_ready_i,
  output logic [INS_W-1:0]         ins_o,
  output logic                     ins_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  import mpc_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  seq_state_t       state_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_eff;
  logic [INS_W-1:0] ins_q, rdata, first_word;
  logic             ins_valid_q, busy_q, done_q, overflow_q;
  logic             wr_ok, xfer, last, loop_go;

`ifdef MPC_SEQ_LOOP_EN
  assign loop_go = loop_i;
`else
  assign loop_go = 1'b0;
`endif

  assign wr_ok     = (state_q == IDLE) && wr_en_i && !clear_i && (count_q < CNT_W'(DEPTH));
  assign xfer      = ins_valid_q && ins_ready_i;
  assign last      = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));
  assign count_eff = clear_i ? '0 : count_q + CNT_W'(wr_ok);
  // A word written in the start cycle into an empty buffer is not yet readable.
  assign first_word = (wr_ok && (count_q == '0)) ? wr_data_i : rdata;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (state_q != RUN) rd_ptr_d = '0;
    else if (xfer)      rd_ptr_d = last ? '0 : rd_ptr_q + PTR_W'(1);
  end

  mpc_seq_mem #(.DEPTH(DEPTH), .INS_W(INS_W)) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (count_q[PTR_W-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
          end else if (wr_en_i) begin
            if (wr_ok) count_q <= count_q + CNT_W'(1);
            else       overflow_q <= 1'b1;
          end
          if (start_i) begin
            rd_ptr_q <= '0;
            if (count_eff != '0) begin
              state_q     <= RUN;
              busy_q      <= 1'b1;
              ins_valid_q <= 1'b1;
              ins_q       <= first_word;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_en_i) overflow_q <= 1'b1;
          if (xfer) begin
            if (last && !loop_go) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              ins_valid_q <= 1'b0;
              ins_q       <= '0;
              done_q      <= 1'b1;
              rd_ptr_q    <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_d;
              ins_q    <= rdata;
            end
          end
        end
        default: begin
          if (wr_en_i) overflow_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ins_o       = ins_q;
  assign ins_valid_o = ins_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

endmodule
